// File: rtl/tacometro_pkg.sv
// Shared definitions for the pulse tachometer: FSM state codes and default sizing.
package tacometro_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ARMED = 2'd1;
    localparam logic [1:0] COUNT = 2'd2;

    localparam int unsigned CNT_W_DEF           = 16;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;

    typedef enum logic [1:0] {
        StIdle  = IDLE,
        StArmed = ARMED,
        StCount = COUNT
    } estado_t;

endpackage

// File: rtl/filtro_entrada.sv
// Sensor input conditioning: 2-FF synchronizer, stability filter and rising-edge pulse.
module filtro_entrada
    import tacometro_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic raw_in,
    output logic level_out,
    output logic rise_pulse
);

    localparam int unsigned     DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            level_q, level_d;
    logic            level_prev_q;
    logic            rise_q;

    // The counter tracks how long the synced input has disagreed with the accepted level.
    always_comb begin
        db_cnt_d = '0;
        level_d  = level_q;
        if (sync2_q != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                level_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            db_cnt_q     <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            rise_q       <= 1'b0;
        end else begin
            sync1_q      <= raw_in;
            sync2_q      <= sync1_q;
            db_cnt_q     <= db_cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
            rise_q       <= level_q & ~level_prev_q;
        end
    end

    assign level_out  = level_q;
    assign rise_pulse = rise_q;

endmodule

// File: rtl/tacometro_pulsos.sv
// Pulse tachometer: counts filtered sensor rising edges per gate window and reports
// the saturated count with a one-cycle valid at every window close.
module tacometro_pulsos
    import tacometro_pkg::*;
#(
    parameter int unsigned CNT_W           = CNT_W_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             gate_tick,
    input  logic             enc_in,
    input  logic             enable,
    output logic [CNT_W-1:0] count_out,
    output logic             count_valid,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] ACC_MAX = '1;

    estado_t          state_q, state_d;
    logic [CNT_W-1:0] acc_q, acc_d, acc_inc;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             overflow_q, overflow_d;
    logic             valid_q, valid_d;
    logic             sat_hit;
    logic             evento;
    logic             unused_level;

    // Only the edge pulse drives the counter; the filtered level is not needed here.
    filtro_entrada #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_filtro (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .raw_in    (enc_in),
        .level_out (unused_level),
        .rise_pulse(evento)
    );

    always_comb begin
        // An event arriving with the accumulator full is lost and flags the window.
        sat_hit    = evento && (acc_q == ACC_MAX);
        acc_inc    = (evento && !sat_hit) ? acc_q + CNT_W'(1) : acc_q;
        state_d    = state_q;
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        valid_d    = 1'b0;
        case (state_q)
            StIdle: begin
                acc_d = '0;
                ovf_d = 1'b0;
                if (enable) begin
                    state_d = StArmed;
                end
            end
            StArmed: begin
                acc_d = '0;
                ovf_d = 1'b0;
                if (!enable) begin
                    state_d = StIdle;
                end else if (gate_tick) begin
                    state_d = StCount;
                end
            end
            StCount: begin
                if (!enable) begin
                    state_d = StIdle;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                end else if (gate_tick) begin
                    count_d    = acc_inc;
                    overflow_d = ovf_q | sat_hit;
                    valid_d    = 1'b1;
                    acc_d      = '0;
                    ovf_d      = 1'b0;
                end else begin
                    acc_d = acc_inc;
                    ovf_d = ovf_q | sat_hit;
                end
            end
            default: begin
                state_d = StIdle;
                acc_d   = '0;
                ovf_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
        end
    end

    assign count_out   = count_q;
    assign count_valid = valid_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_tacometro_pulsos.sv
// Bench for tacometro_pulsos: window-level reference model checked every cycle on a
// 16-bit and a 4-bit instance, plus table rows and hand-written corner sequences.
module tb_tacometro_pulsos;

    localparam int D   = 4;
    localparam int PER = 200;

    logic        clk_in = 1'b0;
    logic        rst_n = 1'b0;
    logic        gate_tick = 1'b0;
    logic        enc_in = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] count_out;
    logic        count_valid, overflow;
    logic [3:0]  count_out4;
    logic        count_valid4, overflow4;

    always #5 clk_in = ~clk_in;

    tacometro_pulsos #(.CNT_W(16), .DEBOUNCE_CYCLES(D)) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .gate_tick  (gate_tick),
        .enc_in     (enc_in),
        .enable     (enable),
        .count_out  (count_out),
        .count_valid(count_valid),
        .overflow   (overflow)
    );

    tacometro_pulsos #(.CNT_W(4), .DEBOUNCE_CYCLES(D)) dut4 (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .gate_tick  (gate_tick),
        .enc_in     (enc_in),
        .enable     (enable),
        .count_out  (count_out4),
        .count_valid(count_valid4),
        .overflow   (overflow4)
    );

    int cyc;
    int n_cmp;
    int n_bad;
    bit wave[$];
    int ev_q[$];
    bit double_tick;

    // Window-level model: unbounded pulse count per window, clamped only when reported.
    bit m_on, m_meas;
    int m_n;
    int exp_out16, exp_out4;
    bit exp_ovf16, exp_ovf4, exp_valid;

    typedef struct {
        int pulses;
        int hi;
        int lo;
        int glitches;
        bit on_tick;
        int exp16;
        bit ovf16;
        int exp4;
        bit ovf4;
    } row_t;
    row_t rows[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s edge=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_on = 0; m_meas = 0; m_n = 0;
        exp_out16 = 0; exp_out4 = 0; exp_ovf16 = 0; exp_ovf4 = 0; exp_valid = 0;
        ev_q.delete();
    endtask

    task automatic model(input bit g, input bit en, input bit ev);
        exp_valid = 0;
        if (!en) begin
            m_on = 0; m_meas = 0; m_n = 0;
        end else if (!m_on) begin
            m_on = 1;
        end else if (!m_meas) begin
            if (g) begin
                m_meas = 1; m_n = 0;
            end
        end else begin
            if (ev) m_n++;
            if (g) begin
                exp_valid = 1;
                exp_out16 = (m_n > 65535) ? 65535 : m_n;
                exp_ovf16 = (m_n > 65535);
                exp_out4  = (m_n > 15) ? 15 : m_n;
                exp_ovf4  = (m_n > 15);
                m_n = 0;
            end
        end
    endtask

    // One clock edge: update the model with the sampled inputs, check, drive next inputs.
    task automatic step();
        bit ev;
        @(posedge clk_in);
        cyc++;
        ev = 0;
        while (ev_q.size() > 0 && ev_q[0] <= cyc) begin
            if (ev_q[0] == cyc) ev = 1;
            void'(ev_q.pop_front());
        end
        if (!rst_n) model_reset();
        else model(gate_tick, enable, ev);
        #1;
        chk("valid16", count_valid, exp_valid);
        chk("count16", count_out, exp_out16);
        chk("ovf16", overflow, exp_ovf16);
        chk("valid4", count_valid4, exp_valid);
        chk("count4", count_out4, exp_out4);
        chk("ovf4", overflow4, exp_ovf4);
        enc_in = (wave.size() > 0) ? wave.pop_front() : 1'b0;
        gate_tick = ((cyc + 1) % PER == 0) || (double_tick && ((cyc + 1) % PER == 1));
    endtask

    task automatic run_to_tick();
        do step(); while (cyc % PER != 0);
    endtask

    // A clean pulse is first sampled at edge cyc+2+idx; its event reaches the counter 3+D later.
    task automatic push_pulse(input int lo, input int hi, input bit clean);
        for (int i = 0; i < lo; i++) wave.push_back(1'b0);
        if (clean) ev_q.push_back(cyc + 2 + wave.size() + 3 + D);
        for (int i = 0; i < hi; i++) wave.push_back(1'b1);
    endtask

    task automatic push_aligned(input int target_edge);
        push_pulse(target_edge - cyc - 5 - D - wave.size(), 10, 1'b1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog edge=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0; double_tick = 0;
        model_reset();
        rows[0] = '{7, 10, 10, 0, 0, 7, 0, 7, 0};
        rows[1] = '{3, 10, 10, 8, 0, 3, 0, 3, 0};
        rows[2] = '{20, 5, 4, 0, 0, 20, 0, 15, 1};
        rows[3] = '{3, 10, 10, 0, 0, 3, 0, 3, 0};
        rows[4] = '{5, 10, 10, 0, 1, 6, 0, 6, 0};
        rows[5] = '{0, 10, 10, 0, 0, 0, 0, 0, 0};

        repeat (3) step();
        rst_n = 1; enable = 1;
        run_to_tick();

        for (int r = 0; r < 6; r++) begin
            for (int g = 0; g < rows[r].glitches; g++) push_pulse(6, 2, 1'b0);
            for (int p = 0; p < rows[r].pulses; p++) push_pulse(rows[r].lo, rows[r].hi, 1'b1);
            if (rows[r].on_tick) push_aligned(cyc + PER);
            run_to_tick();
            chk($sformatf("row%0d_valid", r), count_valid, 1);
            chk($sformatf("row%0d_count16", r), count_out, rows[r].exp16);
            chk($sformatf("row%0d_ovf16", r), overflow, rows[r].ovf16);
            chk($sformatf("row%0d_count4", r), count_out4, rows[r].exp4);
            chk($sformatf("row%0d_ovf4", r), overflow4, rows[r].ovf4);
        end

        // Disable mid-window, then re-enable mid-window.
        for (int p = 0; p < 4; p++) push_pulse(10, 10, 1'b1);
        run_to_tick();
        chk("pre_disable_count", count_out, 4);
        for (int p = 0; p < 5; p++) push_pulse(10, 10, 1'b1);
        repeat (110) step();
        enable = 0;
        run_to_tick();
        chk("disabled_no_valid", count_valid, 0);
        chk("disabled_hold", count_out, 4);
        repeat (20) step();
        enable = 1;
        run_to_tick();
        chk("reenable_silent", count_valid, 0);
        chk("reenable_hold", count_out, 4);
        for (int p = 0; p < 2; p++) push_pulse(10, 10, 1'b1);
        run_to_tick();
        chk("reenable_valid", count_valid, 1);
        chk("reenable_count", count_out, 2);

        // Back-to-back ticks with an event on the second one.
        for (int p = 0; p < 3; p++) push_pulse(10, 10, 1'b1);
        push_aligned(cyc + PER + 1);
        double_tick = 1;
        run_to_tick();
        chk("dbl_first_valid", count_valid, 1);
        chk("dbl_first_count", count_out, 3);
        step();
        double_tick = 0;
        chk("dbl_second_valid", count_valid, 1);
        chk("dbl_second_count", count_out, 1);
        run_to_tick();

        // Disable landing on a tick, then enable rising on a tick.
        for (int p = 0; p < 2; p++) push_pulse(10, 10, 1'b1);
        repeat (PER - 1) step();
        enable = 0;
        step();
        chk("dis_on_tick_valid", count_valid, 0);
        repeat (PER - 1) step();
        enable = 1;
        step();
        chk("en_on_tick_valid", count_valid, 0);
        run_to_tick();
        chk("arm_silent", count_valid, 0);
        push_pulse(10, 10, 1'b1);
        run_to_tick();
        chk("after_arm_count", count_out, 1);

        // Level held high across several windows yields a single event.
        push_pulse(5, 450, 1'b1);
        run_to_tick();
        chk("held_high_first", count_out, 1);
        run_to_tick();
        chk("held_high_second", count_out, 0);
        run_to_tick();

        // Randomized windows with glitches, enable drops and occasional double ticks.
        for (int w = 0; w < 8; w++) begin
            int off_s;
            int off_l;
            while (wave.size() < 170) begin
                if ($urandom_range(0, 3) == 0)
                    push_pulse($urandom_range(5, 12), $urandom_range(1, 2), 1'b0);
                else
                    push_pulse($urandom_range(5, 12), $urandom_range(5, 12), 1'b1);
            end
            off_s = $urandom_range(0, PER - 1);
            off_l = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 60) : 0;
            double_tick = ($urandom_range(0, 3) == 0);
            for (int i = 1; i <= PER; i++) begin
                enable = !(i > off_s && i <= off_s + off_l);
                step();
            end
            double_tick = 0;
            enable = 1;
        end

        // Reset in the middle of a window.
        while (wave.size() > 0 || ev_q.size() > 0) step();
        repeat (10) step();
        run_to_tick();
        run_to_tick();
        for (int p = 0; p < 7; p++) push_pulse(10, 10, 1'b1);
        run_to_tick();
        chk("pre_reset_count", count_out, 7);
        for (int p = 0; p < 3; p++) push_pulse(10, 10, 1'b1);
        repeat (90) step();
        rst_n = 0;
        #2;
        chk("async_reset_count", count_out, 0);
        chk("async_reset_valid", count_valid, 0);
        chk("async_reset_ovf", overflow, 0);
        chk("async_reset_count4", count_out4, 0);
        repeat (3) step();
        rst_n = 1;
        run_to_tick();
        chk("post_reset_arm", count_valid, 0);
        run_to_tick();
        chk("post_reset_first_valid", count_valid, 1);
        chk("post_reset_first_count", count_out, 0);
        repeat (5) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
